// File: rtl/if_fetch_unit_pkg.sv
// if_fetch_unit_pkg: shared types and constants for the instruction-fetch front end
package if_fetch_unit_pkg;
  typedef enum logic {IDLE, RUN} state_t;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic CHIP_ENABLE = 1'b1;
  localparam logic CHIP_DISABLE = 1'b0;
endpackage

// File: rtl/if_fetch_unit_if.sv
// if_fetch_unit_if: ctrl/ID redirect inputs, ROM port and ID output bundle of the fetch unit
interface if_fetch_unit_if #(parameter int ADDR_W = 32, parameter int INST_W = 32);
  logic stall;
  logic branch_flag;
  logic [ADDR_W-1:0] branch_target;
  logic rom_ce;
  logic [ADDR_W-1:0] rom_addr;
  logic [INST_W-1:0] rom_data;
  logic [ADDR_W-1:0] id_pc;
  logic [INST_W-1:0] id_inst;
  logic id_valid;
  modport master (
    input stall, branch_flag, branch_target, rom_data,
    output rom_ce, rom_addr, id_pc, id_inst, id_valid
  );
  modport slave (
    output stall, branch_flag, branch_target, rom_data,
    input rom_ce, rom_addr, id_pc, id_inst, id_valid
  );
endinterface

// File: rtl/if_skid_reg.sv
// if_skid_reg: one-entry {pc, inst} holding register for a synchronous-memory read that lands during a stall
module if_skid_reg #(
  parameter int ADDR_W = 32,
  parameter int INST_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              clr,
  input  logic [ADDR_W-1:0] d_pc,
  input  logic [INST_W-1:0] d_inst,
  output logic              valid,
  output logic [ADDR_W-1:0] q_pc,
  output logic [INST_W-1:0] q_inst
);
  // capture on load, drop on clear (clear wins)
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      valid  <= 1'b0;
      q_pc   <= '0;
      q_inst <= '0;
    end else if (clr) begin
      valid <= 1'b0;
    end else if (load) begin
      valid  <= 1'b1;
      q_pc   <= d_pc;
      q_inst <= d_inst;
    end
endmodule

// File: rtl/if_fetch_unit.sv
// if_fetch_unit: PC, ROM issue and ID register with stall skid and branch redirect
module if_fetch_unit
  import if_fetch_unit_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int INST_W = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEFAULT_RESET_PC)
) (
  input logic clk,
  input logic rst,
  if_fetch_unit_if.master bus
);
  state_t state, state_nx;
  logic run, br, issue, skid_load, skid_clr, skid_valid, req_valid;
  logic [ADDR_W-1:0] pc, req_pc, skid_pc, tgt;
  logic [INST_W-1:0] skid_inst;
  assign tgt = bus.branch_target & ~ADDR_W'(3);
  assign bus.rom_ce = issue ? CHIP_ENABLE : CHIP_DISABLE;
  assign bus.rom_addr = pc;
  // state register: IDLE only while reset is held
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else state <= state_nx;
  // next state and per-cycle control; branch outranks stall, both ignored in IDLE
  always_comb begin
    state_nx = RUN;
    run = state == RUN;
    br = run & bus.branch_flag;
    issue = run & ~bus.stall & ~bus.branch_flag;
    skid_load = run & bus.stall & ~bus.branch_flag & req_valid;
    skid_clr = br | (issue & skid_valid);
  end
  // PC and the read currently in flight in the ROM
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      pc <= RESET_PC;
      req_valid <= 1'b0;
      req_pc <= '0;
    end else begin
      pc <= br ? tgt : issue ? pc + ADDR_W'(4) : pc;
      req_valid <= issue;
      if (issue) req_pc <= pc;
    end
  if_skid_reg #(.ADDR_W(ADDR_W), .INST_W(INST_W)) u_skid (
    .clk(clk),
    .rst(rst),
    .load(skid_load),
    .clr(skid_clr),
    .d_pc(req_pc),
    .d_inst(bus.rom_data),
    .valid(skid_valid),
    .q_pc(skid_pc),
    .q_inst(skid_inst)
  );
  // ID register: skid first, then the arriving ROM word, else a bubble; branch flushes
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      bus.id_valid <= 1'b0;
      bus.id_pc <= '0;
      bus.id_inst <= '0;
    end else if (br) begin
      bus.id_valid <= 1'b0;
      bus.id_pc <= '0;
      bus.id_inst <= '0;
    end else if (issue) begin
      bus.id_valid <= skid_valid | req_valid;
      bus.id_pc <= skid_valid ? skid_pc : req_valid ? req_pc : '0;
      bus.id_inst <= skid_valid ? skid_inst : req_valid ? bus.rom_data : '0;
    end
endmodule

// File: tb/tb_if_fetch_unit.sv
// tb_if_fetch_unit: scoreboard bench for reset, stall, branch, wrap and reset-mid-stall
module tb_if_fetch_unit;
  typedef struct packed {logic v; logic [31:0] pc;} exp_t;
  logic clk, rst;
  int n_run, n_fail;
  exp_t sb[$];
  exp_t e;
  if_fetch_unit_if #(.ADDR_W(32), .INST_W(32)) b1 ();
  if_fetch_unit_if #(.ADDR_W(32), .INST_W(32)) b2 ();
  if_fetch_unit u1 (.clk(clk), .rst(rst), .bus(b1));
  if_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) u2 (.clk(clk), .rst(rst), .bus(b2));

  initial begin
    clk = 0;
    #10;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) begin
    if (b1.rom_ce) b1.rom_data <= {16'hA5A5, b1.rom_addr[15:0]};
    if (b2.rom_ce) b2.rom_data <= {16'hA5A5, b2.rom_addr[15:0]};
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 0;
    b1.stall = 0; b1.branch_flag = 0; b1.branch_target = '0;
    b2.stall = 0; b2.branch_flag = 0; b2.branch_target = '0;
    #20;
    n_run++;
    if ({b1.rom_ce, b1.id_valid, b1.rom_addr, b1.id_pc, b1.id_inst} !== {1'b0, 1'b0, 32'h0, 32'h0, 32'h0}) begin
      n_fail++;
      $display("FAIL reset_state: ce=%b v=%b addr=%h pc=%h inst=%h want 0/0/0/0/0", b1.rom_ce, b1.id_valid, b1.rom_addr, b1.id_pc, b1.id_inst);
    end
    #175 rst = 1;
    cyc();
    n_run++;
    if ({b1.rom_ce, b1.rom_addr, b1.id_valid} !== {1'b1, 32'h0, 1'b0}) begin
      n_fail++;
      $display("FAIL first_issue: ce=%b addr=%h v=%b want 1/0/0", b1.rom_ce, b1.rom_addr, b1.id_valid);
    end
    cyc();
    n_run++;
    if ({b1.rom_addr, b1.id_valid} !== {32'h4, 1'b0}) begin
      n_fail++;
      $display("FAIL second_issue: addr=%h v=%b want 4/0", b1.rom_addr, b1.id_valid);
    end
    sb.push_back('{1'b1, 32'h0});
    sb.push_back('{1'b1, 32'h4});
    while (sb.size() > 0) begin
      cyc();
      e = sb.pop_front();
      n_run++;
      if ({b1.id_valid, b1.id_pc, b1.id_inst} !== {e.v, e.pc, e.v ? {16'hA5A5, e.pc[15:0]} : 32'h0}) begin
        n_fail++;
        $display("FAIL reset_stream: got %b/%h/%h want %b/%h", b1.id_valid, b1.id_pc, b1.id_inst, e.v, e.pc);
      end
    end
  endtask

  task automatic test_stall();
    b1.stall = 1;
    #1;
    n_run++;
    if (b1.rom_ce !== 1'b0) begin
      n_fail++;
      $display("FAIL stall_ce: got %b want 0", b1.rom_ce);
    end
    sb.push_back('{1'b1, 32'h4});
    sb.push_back('{1'b1, 32'h8});
    sb.push_back('{1'b1, 32'hC});
    while (sb.size() > 0) begin
      cyc();
      b1.stall = 0;
      e = sb.pop_front();
      n_run++;
      if ({b1.id_valid, b1.id_pc, b1.id_inst} !== {e.v, e.pc, e.v ? {16'hA5A5, e.pc[15:0]} : 32'h0}) begin
        n_fail++;
        $display("FAIL stall_stream: got %b/%h/%h want %b/%h", b1.id_valid, b1.id_pc, b1.id_inst, e.v, e.pc);
      end
    end
  endtask

  task automatic test_branch(input logic with_stall, input logic [31:0] tgt);
    b1.branch_flag = 1;
    b1.branch_target = tgt;
    b1.stall = with_stall;
    #1;
    n_run++;
    if (b1.rom_ce !== 1'b0) begin
      n_fail++;
      $display("FAIL branch_ce: stall=%b got %b want 0", with_stall, b1.rom_ce);
    end
    sb.push_back('{1'b0, 32'h0});
    sb.push_back('{1'b0, 32'h0});
    sb.push_back('{1'b1, tgt & ~32'h3});
    sb.push_back('{1'b1, (tgt & ~32'h3) + 32'h4});
    for (int i = 0; i < 4; i++) begin
      cyc();
      if (i == 0) begin
        b1.branch_flag = 0;
        b1.stall = 0;
        #1;
        n_run++;
        if ({b1.rom_ce, b1.rom_addr} !== {1'b1, tgt & ~32'h3}) begin
          n_fail++;
          $display("FAIL branch_target_issue: stall=%b ce=%b addr=%h want 1/%h", with_stall, b1.rom_ce, b1.rom_addr, tgt & ~32'h3);
        end
      end
      e = sb.pop_front();
      n_run++;
      if ({b1.id_valid, b1.id_pc, b1.id_inst} !== {e.v, e.pc, e.v ? {16'hA5A5, e.pc[15:0]} : 32'h0}) begin
        n_fail++;
        $display("FAIL branch_stream: stall=%b got %b/%h/%h want %b/%h", with_stall, b1.id_valid, b1.id_pc, b1.id_inst, e.v, e.pc);
      end
    end
  endtask

  task automatic test_long_stall();
    b1.stall = 1;
    sb.push_back('{1'b1, 32'h204});
    sb.push_back('{1'b1, 32'h204});
    sb.push_back('{1'b1, 32'h204});
    sb.push_back('{1'b1, 32'h208});
    sb.push_back('{1'b1, 32'h20C});
    sb.push_back('{1'b1, 32'h210});
    for (int i = 0; i < 6; i++) begin
      cyc();
      if (i == 2) b1.stall = 0;
      e = sb.pop_front();
      n_run++;
      if ({b1.id_valid, b1.id_pc, b1.id_inst} !== {e.v, e.pc, e.v ? {16'hA5A5, e.pc[15:0]} : 32'h0}) begin
        n_fail++;
        $display("FAIL long_stall_stream: got %b/%h/%h want %b/%h", b1.id_valid, b1.id_pc, b1.id_inst, e.v, e.pc);
      end
    end
  endtask

  task automatic test_reset_mid_stall();
    b1.stall = 1;
    cyc();
    n_run++;
    if ({b1.id_valid, b1.id_pc} !== {1'b1, 32'h210}) begin
      n_fail++;
      $display("FAIL pre_reset_hold: got %b/%h want 1/210", b1.id_valid, b1.id_pc);
    end
    #2 rst = 0;
    #1;
    n_run++;
    if ({b1.id_valid, b1.rom_ce, b1.rom_addr, b1.id_pc} !== {1'b0, 1'b0, 32'h0, 32'h0}) begin
      n_fail++;
      $display("FAIL async_reset: v=%b ce=%b addr=%h pc=%h want 0/0/0/0", b1.id_valid, b1.rom_ce, b1.rom_addr, b1.id_pc);
    end
    b1.stall = 0;
    @(negedge clk);
    @(negedge clk);
    rst = 1;
    cyc();
    n_run++;
    if ({b1.rom_ce, b1.rom_addr} !== {1'b1, 32'h0}) begin
      n_fail++;
      $display("FAIL restart_issue: ce=%b addr=%h want 1/0", b1.rom_ce, b1.rom_addr);
    end
    sb.push_back('{1'b0, 32'h0});
    sb.push_back('{1'b1, 32'h0});
    sb.push_back('{1'b1, 32'h4});
    while (sb.size() > 0) begin
      cyc();
      e = sb.pop_front();
      n_run++;
      if ({b1.id_valid, b1.id_pc, b1.id_inst} !== {e.v, e.pc, e.v ? {16'hA5A5, e.pc[15:0]} : 32'h0}) begin
        n_fail++;
        $display("FAIL restart_stream: got %b/%h/%h want %b/%h", b1.id_valid, b1.id_pc, b1.id_inst, e.v, e.pc);
      end
    end
  endtask

  task automatic test_wrap();
    @(negedge clk);
    rst = 0;
    @(negedge clk);
    rst = 1;
    cyc();
    n_run++;
    if ({b2.rom_ce, b2.rom_addr} !== {1'b1, 32'hFFFF_FFFC}) begin
      n_fail++;
      $display("FAIL wrap_first_issue: ce=%b addr=%h want 1/fffffffc", b2.rom_ce, b2.rom_addr);
    end
    cyc();
    n_run++;
    if ({b2.rom_ce, b2.rom_addr} !== {1'b1, 32'h0}) begin
      n_fail++;
      $display("FAIL wrap_second_issue: ce=%b addr=%h want 1/0", b2.rom_ce, b2.rom_addr);
    end
    sb.push_back('{1'b1, 32'hFFFF_FFFC});
    sb.push_back('{1'b1, 32'h0});
    sb.push_back('{1'b1, 32'h4});
    while (sb.size() > 0) begin
      cyc();
      e = sb.pop_front();
      n_run++;
      if ({b2.id_valid, b2.id_pc, b2.id_inst} !== {e.v, e.pc, e.v ? {16'hA5A5, e.pc[15:0]} : 32'h0}) begin
        n_fail++;
        $display("FAIL wrap_stream: got %b/%h/%h want %b/%h", b2.id_valid, b2.id_pc, b2.id_inst, e.v, e.pc);
      end
    end
  endtask

  initial begin
    n_run = 0;
    n_fail = 0;
    test_reset();
    test_stall();
    test_branch(1'b0, 32'h103);
    test_branch(1'b1, 32'h203);
    test_long_stall();
    test_reset_mid_stall();
    test_wrap();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
